lcd_spi_sequencer: RTL and testbench



---
 rtl/lcd_spi_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 36 +++
 rtl/lcd_spi_sequencer.sv | 138 +++++++++++++
 tb/tb_lcd_spi_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI sequencer: state encoding,
// D/C line polarity and requester indices.
package lcd_spi_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // Bit positions of the two requesters on the arbiter request/grant vectors
  localparam int REQ_CMD = 0;
  localparam int REQ_DAT = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// vector and a registered last-winner pointer; the pointer only moves when a
// grant is actually issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last_one;

  // Single requester wins outright; on a tie the side not served last wins
  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_one ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer starts at "index 1 served last" so index 0 takes the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_one <= 1'b1;
    end else if (grant != 2'b00) begin
      last_one <= grant[1];
    end
  end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// Shares one SPI master between a command source and a pixel/data source,
// frames each byte with LCD chip-select and D/C, and aborts transfers whose
// done pulse never comes back.
//
// state | meaning
// IDLE  | cs_n high, waiting for a request; arbitration happens here
// SETUP | cs_n low, byte and D/C stable, counting CS_SETUP cycles
// START | spi_start high for this single cycle
// WAIT  | waiting for spi_done, watchdog counting toward TIMEOUT
// HOLD  | cs_n still low, counting CS_HOLD cycles before release
module lcd_spi_sequencer
  import lcd_spi_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic              fast_clk,
  input  logic              rst,
  input  logic              cmd_req,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ack,
  input  logic              dat_req,
  input  logic [DATA_W-1:0] dat_data,
  output logic              dat_ack,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_done,
  output logic              lcd_cs_n,
  output logic              lcd_dc,
  output logic              busy,
  output logic              timeout_err
);

  // Counters run up from zero; these are the values seen on the final cycle
  localparam logic [3:0]  SETUP_LAST = 4'(CS_SETUP - 1);
  localparam logic [3:0]  HOLD_LAST  = 4'(CS_HOLD - 1);
  localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [3:0]  phase_cnt;
  logic [15:0] wd_cnt;
  logic [1:0]  req_vec;
  logic [1:0]  grant;

  assign req_vec[REQ_CMD] = cmd_req;
  assign req_vec[REQ_DAT] = dat_req;

  rr_arbiter2 u_arb (
    .clk      (fast_clk),
    .rst      (rst),
    .req      (req_vec),
    .grant_en (state == ST_IDLE),
    .grant    (grant)
  );

  // Transfer sequencer; every output is a register updated on the state change
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      wd_cnt      <= '0;
      cmd_ack     <= 1'b0;
      dat_ack     <= 1'b0;
      spi_start   <= 1'b0;
      spi_data    <= '0;
      lcd_cs_n    <= 1'b1;
      lcd_dc      <= DC_CMD;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cmd_ack     <= 1'b0;
      dat_ack     <= 1'b0;
      spi_start   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            state     <= ST_SETUP;
            phase_cnt <= '0;
            busy      <= 1'b1;
            lcd_cs_n  <= 1'b0;
            if (grant[REQ_CMD]) begin
              cmd_ack  <= 1'b1;
              spi_data <= cmd_data;
              lcd_dc   <= DC_CMD;
            end else begin
              dat_ack  <= 1'b1;
              spi_data <= dat_data;
              lcd_dc   <= DC_DATA;
            end
          end
        end
        ST_SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            state     <= ST_START;
            spi_start <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        ST_START: begin
          state  <= ST_WAIT;
          wd_cnt <= '0;
        end
        ST_WAIT: begin
          // A done pulse landing on the watchdog's last cycle still counts as success
          if (spi_done) begin
            state     <= ST_HOLD;
            phase_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            state       <= ST_HOLD;
            phase_cnt   <= '0;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        ST_HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            state    <= ST_IDLE;
            lcd_cs_n <= 1'b1;
            busy     <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          lcd_cs_n <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Self-checking bench for lcd_spi_sequencer. Granted bytes are checked
// against a scoreboard of expected (kind, byte) pairs; timing is checked
// directly in the test sequence.
module tb_lcd_spi_sequencer;

  localparam int DATA_W   = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TIMEOUT  = 20;
  localparam int LIMIT    = 200;

  localparam int W_START = 0;
  localparam int W_CSN   = 1;
  localparam int W_TOERR = 2;
  localparam int W_ACK   = 3;

  typedef struct packed {
    logic              is_dat;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              fast_clk = 1'b0;
  logic              rst;
  logic              cmd_req, dat_req, spi_done;
  logic [DATA_W-1:0] cmd_data, dat_data;
  logic              cmd_ack, dat_ack, spi_start, lcd_cs_n, lcd_dc, busy, timeout_err;
  logic [DATA_W-1:0] spi_data;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   to_count = 0;
  int   cyc      = 0;
  logic prev_ack = 1'b0;

  lcd_spi_sequencer #(
    .DATA_W   (DATA_W),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .fast_clk    (fast_clk),
    .rst         (rst),
    .cmd_req     (cmd_req),
    .cmd_data    (cmd_data),
    .cmd_ack     (cmd_ack),
    .dat_req     (dat_req),
    .dat_data    (dat_data),
    .dat_ack     (dat_ack),
    .spi_start   (spi_start),
    .spi_data    (spi_data),
    .spi_done    (spi_done),
    .lcd_cs_n    (lcd_cs_n),
    .lcd_dc      (lcd_dc),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 fast_clk = ~fast_clk;

  always @(posedge fast_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge fast_clk);
  endtask

  function automatic logic sig(input int w);
    case (w)
      W_START: return spi_start;
      W_CSN:   return lcd_cs_n;
      W_TOERR: return timeout_err;
      W_ACK:   return cmd_ack | dat_ack;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic val, input string tag);
    int n = 0;
    while (sig(w) !== val && n < LIMIT) begin
      tick();
      n++;
    end
    check(tag, 32'(sig(w)), 32'(val));
  endtask

  // Scoreboard: every ack must match the next expected grant
  always @(negedge fast_clk) begin
    exp_t e;
    if (timeout_err) to_count++;
    if (cmd_ack || dat_ack) begin
      check("ack_width", 32'(prev_ack), 32'd0);
      check("ack_onehot", 32'(cmd_ack & dat_ack), 32'd0);
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_kind", 32'(dat_ack), 32'(e.is_dat));
        check("lcd_dc", 32'(lcd_dc), 32'(e.is_dat));
        check("spi_data", 32'(spi_data), 32'(e.data));
      end
    end
    prev_ack = cmd_ack | dat_ack;
  end

  task automatic do_reset();
    rst = 1'b1; cmd_req = 1'b0; dat_req = 1'b0; spi_done = 1'b0;
    tick();
    tick();
    check("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_data", 32'(spi_data), 32'd0);
    check("rst_dc", 32'(lcd_dc), 32'd0);
    check("rst_acks", 32'({cmd_ack, dat_ack, timeout_err}), 32'd0);
    rst = 1'b0;
  endtask

  // Return done after `extra` idle WAIT cycles, then wait for cs release
  task automatic finish_transfer(input int extra);
    wait_for(W_START, 1'b1, "start_seen");
    tick();
    repeat (extra) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    wait_for(W_CSN, 1'b1, "cs_release");
  endtask

  initial begin
    int t0, n, hi, to_before;
    int t_ack[3];
    int extra[3] = '{0, 3, 6};
    cmd_data = '0; dat_data = '0;

    // 1: single command transfer, exact edge timing
    do_reset();
    cmd_req = 1'b1; cmd_data = 8'h2A;
    sb.push_back('{1'b0, 8'h2A});
    tick();
    check("t1_ack", 32'(cmd_ack), 32'd1);
    check("t1_cs_low", 32'(lcd_cs_n), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    cmd_req = 1'b0;
    tick();
    check("t1_start_e2", 32'({spi_start, cmd_ack}), 32'd0);
    tick();
    check("t1_start_e3", 32'(spi_start), 32'd1);
    tick();
    check("t1_start_e4", 32'(spi_start), 32'd0);
    repeat (9) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    check("t1_hold1", 32'(lcd_cs_n), 32'd0);
    tick();
    check("t1_hold2", 32'(lcd_cs_n), 32'd0);
    tick();
    check("t1_cs_rise", 32'(lcd_cs_n), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_no_toerr", 32'(to_count), 32'd0);

    // 2: both requesters tied for four transfers, must alternate
    do_reset();
    cmd_data = 8'hA0; dat_data = 8'hD0;
    sb.push_back('{1'b0, 8'hA0});
    sb.push_back('{1'b1, 8'hD0});
    sb.push_back('{1'b0, 8'hA1});
    sb.push_back('{1'b1, 8'hD1});
    cmd_req = 1'b1; dat_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_for(W_ACK, 1'b1, "t2_ack_seen");
      check("t2_order", 32'(dat_ack), 32'(i % 2));
      check("t2_dc", 32'(lcd_dc), 32'(i % 2));
      if (cmd_ack) cmd_data = cmd_data + 8'h01;
      if (dat_ack) dat_data = dat_data + 8'h01;
      if (i == 3) begin
        cmd_req = 1'b0; dat_req = 1'b0;
      end
      finish_transfer(2);
    end

    // 3: done never returns, watchdog aborts
    do_reset();
    to_before = to_count;
    dat_req = 1'b1; dat_data = 8'h55;
    sb.push_back('{1'b1, 8'h55});
    wait_for(W_ACK, 1'b1, "t3_ack_seen");
    dat_req = 1'b0;
    wait_for(W_START, 1'b1, "t3_start_seen");
    tick();
    n = 0;
    while (!timeout_err && n < LIMIT) begin
      tick();
      n++;
    end
    check("t3_to_latency", 32'(n), 32'(TIMEOUT));
    tick();
    check("t3_to_pulse", 32'(timeout_err), 32'd0);
    check("t3_hold", 32'(lcd_cs_n), 32'd0);
    tick();
    check("t3_cs_rise", 32'(lcd_cs_n), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    tick();
    check("t3_to_count", 32'(to_count - to_before), 32'd1);

    // 4: reset in the middle of WAIT, late done ignored, then normal grant
    do_reset();
    cmd_req = 1'b1; cmd_data = 8'h33;
    sb.push_back('{1'b0, 8'h33});
    wait_for(W_ACK, 1'b1, "t4_ack_seen");
    cmd_req = 1'b0;
    wait_for(W_START, 1'b1, "t4_start_seen");
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("t4_rst_cs", 32'(lcd_cs_n), 32'd1);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_start", 32'(spi_start), 32'd0);
    rst = 1'b0;
    tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    tick();
    check("t4_done_ignored", 32'({busy, ~lcd_cs_n, spi_start}), 32'd0);
    dat_req = 1'b1; dat_data = 8'h77;
    sb.push_back('{1'b1, 8'h77});
    wait_for(W_ACK, 1'b1, "t4_regrant");
    dat_req = 1'b0;
    finish_transfer(1);

    // 5: done during SETUP ignored; done on the timeout edge wins
    do_reset();
    to_before = to_count;
    cmd_req = 1'b1; cmd_data = 8'h11;
    sb.push_back('{1'b0, 8'h11});
    tick();
    cmd_req = 1'b0;
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    check("t5_setup_busy", 32'({busy, spi_start}), 32'd2);
    tick();
    check("t5_start_fires", 32'(spi_start), 32'd1);
    tick();
    repeat (TIMEOUT - 1) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    check("t5_tie_no_err", 32'(timeout_err), 32'd0);
    check("t5_tie_hold", 32'(lcd_cs_n), 32'd0);
    tick();
    tick();
    check("t5_cs_rise", 32'(lcd_cs_n), 32'd1);
    check("t5_to_count", 32'(to_count - to_before), 32'd0);

    // 6: data requester held high, gap and cs-high width between transfers
    do_reset();
    dat_req = 1'b1; dat_data = 8'h3C;
    for (int i = 0; i < 3; i++) sb.push_back('{1'b1, 8'h3C});
    for (int i = 0; i < 3; i++) begin
      wait_for(W_ACK, 1'b1, "t6_ack_seen");
      t_ack[i] = cyc;
      if (i > 0)
        check("t6_gap", 32'(t_ack[i] - t_ack[i-1]),
              32'(CS_SETUP + CS_HOLD + 3 + extra[i-1]));
      if (i == 2) dat_req = 1'b0;
      finish_transfer(extra[i]);
      if (i < 2) begin
        hi = 0;
        while (lcd_cs_n && hi < LIMIT) begin
          tick();
          hi++;
        end
        check("t6_cs_high", 32'(hi), 32'd1);
      end
    end
    tick();
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
